// File: rtl/slc3_mmio_responder.sv
// ---------------------------------------------------------------------------
// slc3_mmio_responder
//
// Memory-side responder for the SLC-3 CPU bus. A read or write request is
// accepted while idle, held for a fixed number of wait states, and then
// completed with a one-cycle ready pulse on R. Requests address either a
// small on-chip RAM at the bottom of the address space or the single I/O
// word at IO_ADDR. Reading IO_ADDR returns the synchronized board switches.
// Writing IO_ADDR loads the register that drives the four seven-segment
// digits.
//
// Ports
//   Clk           : system clock, rising-edge active
//   Reset_n       : asynchronous active-low reset
//   ADDR          : request address (MAR)
//   Data_from_CPU : write data (MDR)
//   MEM_RE        : read request level, held until R is seen
//   MEM_WE        : write request level, held until R is seen; wins over MEM_RE
//   SW            : raw board switches, asynchronous to Clk
//   Data_to_CPU   : registered read data, valid with R and held until next read
//   R             : ready, one-cycle pulse per transaction
//   HEX0..HEX3    : active-low segment drives for hex register nibbles 0..3
// ---------------------------------------------------------------------------
module slc3_mmio_responder #(
  parameter int          LATENCY   = 2,
  parameter int          RAM_WORDS = 256,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        MEM_RE,
  input  logic        MEM_WE,
  input  logic [9:0]  SW,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int          AW       = $clog2(RAM_WORDS);
  localparam logic [16:0] RAM_LIM  = 17'(RAM_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        r_q, r_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  sw_meta_q, sw_sync_q;

  logic [15:0] ram [RAM_WORDS];

  logic [15:0] txn_addr;
  logic [15:0] txn_wdata;
  logic        txn_wr;
  logic        is_io;
  logic        is_ram;
  logic        ack_enter;
  logic        ram_we;

  // Standard active-low 0-F seven-segment patterns, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    // With LATENCY=1 the FSM goes straight from IDLE to ACK, so the request
    // has not been latched yet on that edge; use the live bus in IDLE.
    txn_addr  = (state_q == S_IDLE) ? ADDR          : addr_q;
    txn_wdata = (state_q == S_IDLE) ? Data_from_CPU : wdata_q;
    txn_wr    = (state_q == S_IDLE) ? MEM_WE        : wr_q;
    is_io     = (txn_addr == IO_ADDR);
    is_ram    = !is_io && ({1'b0, txn_addr} < RAM_LIM);

    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    case (state_q)
      S_IDLE: begin
        if (MEM_WE || MEM_RE) begin
          addr_d  = ADDR;
          wdata_d = Data_from_CPU;
          wr_d    = MEM_WE;
          if (LATENCY == 1) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Bus changes are ignored here; only the latched request matters.
        if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_HOLD;
      end
      default: begin
        // A strobe still held from the finished transaction must not restart.
        if (!MEM_RE && !MEM_WE) begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Side effects happen on the edge into ACK so that read data becomes
    // visible in the same cycle as R.
    ack_enter = (state_d == S_ACK);
    r_d       = ack_enter;

    if (ack_enter) begin
      if (txn_wr) begin
        if (is_io) begin
          hex_d = txn_wdata;
        end
      end else if (is_io) begin
        rdata_d = {6'b0, sw_sync_q};
      end else if (is_ram) begin
        rdata_d = ram[txn_addr[AW-1:0]];
      end else begin
        rdata_d = 16'h0000;
      end
    end

    // RAM has no reset; block writes while reset is held so nothing reaches
    // the array from a request seen during reset.
    ram_we = ack_enter && txn_wr && is_ram && Reset_n;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_q      <= 1'b0;
      r_q       <= 1'b0;
      rdata_q   <= 16'h0000;
      hex_q     <= 16'h0000;
      sw_meta_q <= 10'h000;
      sw_sync_q <= 10'h000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      r_q       <= r_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (ram_we) begin
      ram[txn_addr[AW-1:0]] <= txn_wdata;
    end
  end

  assign R           = r_q;
  assign Data_to_CPU = rdata_q;
  assign HEX0        = seg7(hex_q[3:0]);
  assign HEX1        = seg7(hex_q[7:4]);
  assign HEX2        = seg7(hex_q[11:8]);
  assign HEX3        = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_slc3_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_slc3_mmio_responder
//
// Directed bench for slc3_mmio_responder with LATENCY=2, RAM_WORDS=256,
// IO_ADDR=xFFFF. Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_slc3_mmio_responder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] Data_from_CPU = 16'h0000;
  logic        MEM_RE = 1'b0;
  logic        MEM_WE = 1'b0;
  logic [9:0]  SW = 10'h000;
  logic [15:0] Data_to_CPU;
  logic        R;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [27:0] HEX_BEEF = {SEG_B, SEG_E, SEG_E, SEG_F};
  localparam logic [27:0] HEX_0042 = {SEG_0, SEG_0, SEG_4, SEG_2};

  slc3_mmio_responder #(
    .LATENCY  (2),
    .RAM_WORDS(256),
    .IO_ADDR  (16'hFFFF)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .ADDR         (ADDR),
    .Data_from_CPU(Data_from_CPU),
    .MEM_RE       (MEM_RE),
    .MEM_WE       (MEM_WE),
    .SW           (SW),
    .Data_to_CPU  (Data_to_CPU),
    .R            (R),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Drives one request, waits (bounded) for R, keeps the strobe held for
  // 'hold' more cycles, then drops it. lat = falling edges until R (or -1),
  // pulses = number of cycles R was seen high.
  task automatic run_txn(input logic we, input logic re, input logic [15:0] a,
                         input logic [15:0] d, input int hold,
                         output int lat, output int pulses);
    @(negedge Clk);
    ADDR = a; Data_from_CPU = d; MEM_WE = we; MEM_RE = re;
    lat = -1; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (R) begin
        lat = i; pulses = 1;
        break;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (R) pulses++;
    end
    MEM_WE = 1'b0; MEM_RE = 1'b0;
    @(negedge Clk);
    if (R) pulses++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_r: got %b want 0", R); end
    checks++; if (Data_to_CPU !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", Data_to_CPU); end
    checks++; if (HEX0 !== SEG_0) begin errors++; $display("FAIL reset_hex0: got %b want %b", HEX0, SEG_0); end
    checks++; if (HEX1 !== SEG_0) begin errors++; $display("FAIL reset_hex1: got %b want %b", HEX1, SEG_0); end
    checks++; if (HEX2 !== SEG_0) begin errors++; $display("FAIL reset_hex2: got %b want %b", HEX2, SEG_0); end
    checks++; if (HEX3 !== SEG_0) begin errors++; $display("FAIL reset_hex3: got %b want %b", HEX3, SEG_0); end
  endtask

  task automatic test_sw_read();
    int lat, p;
    SW = 10'h031;
    repeat (3) @(negedge Clk);
    run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0000, 3, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_read_latency: got %0d want 2", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL sw_read_pulses: got %0d want 1", p); end
    checks++; if (Data_to_CPU !== 16'h0031) begin errors++; $display("FAIL sw_read_data: got %h want 0031", Data_to_CPU); end
  endtask

  task automatic test_hex_write();
    int lat, p;
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 1, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL hex_write_latency: got %0d want 2", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL hex_write_pulses: got %0d want 1", p); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== HEX_BEEF)
      begin errors++; $display("FAIL hex_write_beef: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, HEX_BEEF); end
    checks++; if (Data_to_CPU !== 16'h0031) begin errors++; $display("FAIL hex_write_data_kept: got %h want 0031", Data_to_CPU); end
    run_txn(1'b0, 1'b1, 16'h0000, 16'h0000, 1, lat, p);
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== HEX_BEEF)
      begin errors++; $display("FAIL hex_after_read: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, HEX_BEEF); end
  endtask

  task automatic test_ram();
    int lat, p;
    run_txn(1'b1, 1'b0, 16'h0005, 16'h1234, 0, lat, p);
    run_txn(1'b1, 1'b0, 16'h0006, 16'hABCD, 0, lat, p);
    run_txn(1'b1, 1'b0, 16'h0000, 16'h0A0A, 0, lat, p);
    run_txn(1'b0, 1'b1, 16'h0005, 16'h0000, 0, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ram_read_latency: got %0d want 2", lat); end
    checks++; if (Data_to_CPU !== 16'h1234) begin errors++; $display("FAIL ram_read5: got %h want 1234", Data_to_CPU); end
    run_txn(1'b0, 1'b1, 16'h0006, 16'h0000, 0, lat, p);
    checks++; if (Data_to_CPU !== 16'hABCD) begin errors++; $display("FAIL ram_read6: got %h want abcd", Data_to_CPU); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== HEX_BEEF)
      begin errors++; $display("FAIL ram_hex_kept: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, HEX_BEEF); end
  endtask

  task automatic test_out_of_range();
    int lat, p;
    run_txn(1'b1, 1'b0, 16'h8000, 16'h5555, 1, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_write_latency: got %0d want 2", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL oor_write_pulses: got %0d want 1", p); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== HEX_BEEF)
      begin errors++; $display("FAIL oor_hex_kept: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, HEX_BEEF); end
    run_txn(1'b0, 1'b1, 16'h0000, 16'h0000, 0, lat, p);
    checks++; if (Data_to_CPU !== 16'h0A0A) begin errors++; $display("FAIL oor_ram0_kept: got %h want 0a0a", Data_to_CPU); end
    run_txn(1'b0, 1'b1, 16'h8000, 16'h0000, 0, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_read_latency: got %0d want 2", lat); end
    checks++; if (Data_to_CPU !== 16'h0000) begin errors++; $display("FAIL oor_read_data: got %h want 0000", Data_to_CPU); end
  endtask

  task automatic test_both_strobes();
    int lat, p;
    run_txn(1'b0, 1'b1, 16'h0005, 16'h0000, 0, lat, p);
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'h0042, 2, lat, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL both_pulses: got %0d want 1", p); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== HEX_0042)
      begin errors++; $display("FAIL both_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, HEX_0042); end
    checks++; if (Data_to_CPU !== 16'h1234) begin errors++; $display("FAIL both_data_kept: got %h want 1234", Data_to_CPU); end
  endtask

  task automatic test_strobe_drop();
    int lat, p;
    @(negedge Clk);
    ADDR = 16'h0006; MEM_RE = 1'b1;
    @(negedge Clk);
    // Accepted; now in the wait state. Drop the strobe and disturb the bus.
    MEM_RE = 1'b0; ADDR = 16'h0005;
    @(negedge Clk);
    checks++; if (R !== 1'b1) begin errors++; $display("FAIL drop_r_high: got %b want 1", R); end
    checks++; if (Data_to_CPU !== 16'hABCD) begin errors++; $display("FAIL drop_data: got %h want abcd", Data_to_CPU); end
    @(negedge Clk);
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL drop_r_low: got %b want 0", R); end
    run_txn(1'b0, 1'b1, 16'h0005, 16'h0000, 0, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL drop_next_latency: got %0d want 2", lat); end
    checks++; if (Data_to_CPU !== 16'h1234) begin errors++; $display("FAIL drop_next_data: got %h want 1234", Data_to_CPU); end
  endtask

  task automatic test_reset_mid();
    int lat, p, rp;
    run_txn(1'b1, 1'b0, 16'h0007, 16'h1111, 0, lat, p);
    @(negedge Clk);
    ADDR = 16'h0007; Data_from_CPU = 16'h7777; MEM_WE = 1'b1;
    @(negedge Clk);
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL rmid_wait_r: got %b want 0", R); end
    Reset_n = 1'b0; MEM_WE = 1'b0;
    rp = 0;
    repeat (3) begin @(negedge Clk); if (R) rp++; end
    Reset_n = 1'b1;
    repeat (3) begin @(negedge Clk); if (R) rp++; end
    checks++; if (rp !== 0) begin errors++; $display("FAIL rmid_no_r: got %0d pulses want 0", rp); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== {SEG_0, SEG_0, SEG_0, SEG_0})
      begin errors++; $display("FAIL rmid_hex_reset: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, {SEG_0, SEG_0, SEG_0, SEG_0}); end
    run_txn(1'b0, 1'b1, 16'h0007, 16'h0000, 0, lat, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rmid_idle_latency: got %0d want 2", lat); end
    checks++; if (Data_to_CPU !== 16'h1111) begin errors++; $display("FAIL rmid_no_write: got %h want 1111", Data_to_CPU); end
  endtask

  initial begin
    test_reset();
    test_sw_read();
    test_hex_write();
    test_ram();
    test_out_of_range();
    test_both_strobes();
    test_strobe_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_mmio_responder.md
Name: slc3_mmio_responder

Overview:
- Memory-side responder for the SLC-3 CPU bus: accepts CPU read/write requests, inserts a fixed number of wait states, then returns a one-cycle ready pulse.
- Serves reads and writes to a small on-chip RAM and to the memory-mapped I/O word at xFFFF.
- At xFFFF, reads return the synchronized switches and writes load the hex-display register.
- Sits between the CPU datapath (MAR/MDR) and the board switches and seven-segment displays.

Parameters:
- LATENCY, 2, cycles from request acceptance to ready pulse; legal range 1..15.
- RAM_WORDS, 256, number of 16-bit RAM words, mapped at x0000..RAM_WORDS-1; must be a power of 2.
- IO_ADDR, 16'hFFFF, address of the switch/hex I/O word.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- ADDR, input, 16, request address (MAR).
- Data_from_CPU, input, 16, write data (MDR).
- MEM_RE, input, 1, read request level; held high until R is seen.
- MEM_WE, input, 1, write request level; held high until R is seen.
- SW, input, 10, raw board switches, asynchronous to Clk.
- Data_to_CPU, output, 16, read data; registered.
- R, output, 1, ready; one-cycle pulse per transaction.
- HEX0..HEX3, output, 7 each, active-low segment drives for hex_reg nibbles 3:0 .. 15:12.

Behaviour:
- Reset (asynchronous, Reset_n=0) values:
  - R=0, Data_to_CPU=16'h0000, hex_reg=16'h0000, so each HEX shows "0" (7'b1000000).
  - FSM returns to IDLE, the wait counter is cleared, and both switch synchronizer stages are cleared.
  - RAM contents are not reset.
- SW path:
  - Two-flop synchronizer; sw_sync lags SW by 2 cycles.
  - Reads return {6'b0, sw_sync}.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - On a cycle with MEM_WE=1 or MEM_RE=1: latch ADDR, Data_from_CPU and the operation type.
  - If both strobes are 1, the transaction is a write; the read is dropped.
  - Next state is ACK if LATENCY=1, otherwise WAIT with the counter set to LATENCY-1.
- WAIT:
  - Decrement the counter; go to ACK when it reaches 1.
  - Changes on ADDR, data or strobes are ignored while in WAIT.
- ACK (R=1 for exactly this cycle):
  - Write to IO_ADDR: hex_reg <= latched data.
  - Write to RAM: RAM[addr] <= latched data.
  - Read of IO_ADDR: Data_to_CPU <= {6'b0, sw_sync}.
  - Read of RAM: Data_to_CPU <= RAM[addr].
  - Any other address: reads return 16'h0000; writes are ignored.
  - Next state is HOLD.
- HOLD:
  - Stay while MEM_RE or MEM_WE is high, so a held strobe never triggers a second transaction.
  - Go to IDLE on the first cycle with both strobes low.
  - R=0 throughout.
- Latency: a request first sampled at edge N produces R high in the cycle following edge N+LATENCY-1, i.e. R is visible LATENCY cycles after acceptance.
- Data_to_CPU is updated together with R and holds its value until the next read's ACK; writes do not change it.
- RAM address uses the low log2(RAM_WORDS) bits of the latched address, valid only when the address is < RAM_WORDS.
- HEX decode:
  - Combinational from the registered hex_reg, standard 0-F active-low patterns.
  - A = 7'b0001000, F = 7'b0001110.
- Strobe drop: if both strobes fall during WAIT, the transaction still completes (R pulses), then the FSM goes HOLD and on to IDLE next cycle.
- Reset mid-transaction: R drops immediately and the pending write does not occur.

Test Plan:
- Reset, then release Reset_n → HEX0..3 = 7'b1000000, R=0, Data_to_CPU=0.
- SW=10'h031, wait 3 cycles, MEM_RE=1 with ADDR=xFFFF, LATENCY=2 → exactly one R pulse 2 cycles after acceptance; Data_to_CPU=16'h0031; no second pulse while MEM_RE stays high.
- MEM_WE=1, ADDR=xFFFF, Data_from_CPU=16'hBEEF → after R, HEX3..0 show B,E,E,F; a following read of x0000 leaves hex_reg unchanged.
- Write x1234 to RAM x0005, drop MEM_WE, then read x0005 → Data_to_CPU=16'h1234.
- Out-of-range access at x8000:
  - Write x5555 → R pulses, RAM and hex_reg unchanged.
  - Read → Data_to_CPU=0.
- Edge cases:
  - MEM_RE=MEM_WE=1 at xFFFF with data x0042 → treated as a write (hex shows 0042), Data_to_CPU unchanged.
  - Reset_n pulsed low during WAIT → R never asserts, FSM in IDLE.
